// File: rtl/mdma_40bx512_ram_slv.sv
// mdma_40bx512_ram_slv: responder end of the MDMA 40b x 512 RAM, each entry SECDED-protected (7 check bits).
// Latency: read result lands RD_LAT (1 or 2) clocks after ren; zero-fill runs 512 clocks after reset.
// Backpressure: none; wen/ren are ignored until init_done, outputs hold until the next read result.
// Optional build macro MDMA_RAM_ERR_INJ_EN adds inj_sbe/inj_dbe write-side error injection ports.
module mdma_40bx512_ram_slv #(
  parameter int RD_LAT = 1,
  parameter int ECC_W  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  wadr,
  input  logic        wen,
  input  logic [39:0] wdat,
`ifdef MDMA_RAM_ERR_INJ_EN
  input  logic        inj_sbe,
  input  logic        inj_dbe,
`endif
  input  logic        ren,
  input  logic [8:0]  radr,
  output logic [39:0] rdat,
  output logic        rsbe,
  output logic        rdbe,
  output logic        init_done
);

  localparam int DW = 40;
  localparam int CW = DW + ECC_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // Hamming check bits: data bits occupy the non-power-of-two positions 3..46.
  function automatic logic [5:0] ham_chk(input logic [DW-1:0] d);
    logic [5:0] c;
    int         k;
    c = '0;
    k = 0;
    for (int p = 3; p < 47; p++) begin
      if ((p & (p - 1)) != 0) begin
        c = c ^ ({6{d[k]}} & p[5:0]);
        k = k + 1;
      end
    end
    return c;
  endfunction

  // Codeword layout: {overall parity, hamming[5:0], data[39:0]}; parity makes the whole word even.
  function automatic logic [CW-1:0] enc_cw(input logic [DW-1:0] d);
    logic [5:0] c;
    c = ham_chk(d);
    return {^{c, d}, c, d};
  endfunction

  // Flip the data bit whose Hamming position equals the syndrome; check-bit positions leave data alone.
  function automatic logic [DW-1:0] fix_dat(input logic [DW-1:0] d, input logic [5:0] syn);
    logic [DW-1:0] r;
    int            k;
    r = d;
    k = 0;
    for (int p = 3; p < 47; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (syn == p[5:0]) r[k] = ~r[k];
        k = k + 1;
      end
    end
    return r;
  endfunction

  logic [CW-1:0] mem_q [0:511];

  state_t        state_q, state_d;
  logic [9:0]    cnt_q, cnt_d;
  logic          mem_we;
  logic [8:0]    mem_wa;
  logic [CW-1:0] mem_wd;
  logic [CW-1:0] wr_cw;

  logic          rd_go;
  logic [CW-1:0] rd_cw;
  logic          p1_vld_q;
  logic [CW-1:0] cw_q;
  logic          res_vld;
  logic [CW-1:0] dec_in;
  logic [5:0]    syn;
  logic          par_bad;
  logic [DW-1:0] dec_dat;
  logic          dec_sbe, dec_dbe;
  logic [DW-1:0] rdat_q;
  logic          rsbe_q, rdbe_q;

  // Master write codeword, optionally corrupted on the way into the array.
  always_comb begin
    wr_cw = enc_cw(wdat);
`ifdef MDMA_RAM_ERR_INJ_EN
    if (inj_dbe) begin
      wr_cw[1:0] = ~wr_cw[1:0];
    end else if (inj_sbe) begin
      wr_cw[0] = ~wr_cw[0];
    end
`endif
  end

  // Next state and write-port steering: zero-fill sweep in INIT, master writes in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = wadr;
    mem_wd  = wr_cw;
    case (state_q)
      ST_INIT: begin
        if (!cnt_q[9]) begin
          // cnt_q 0..511 writes one entry per clock; reaching 512 means the sweep is done.
          mem_we = 1'b1;
          mem_wa = cnt_q[8:0];
          mem_wd = enc_cw('0);
          cnt_d  = cnt_q + 10'd1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  mem_we = wen;
      default: state_d = ST_INIT;
    endcase
  end

  // FSM state and sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array write; contents survive reset and are rewritten by the sweep instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Read source: the same-edge write is not yet visible, which gives read-first collisions.
  assign rd_go   = (state_q == ST_RUN) && ren;
  assign rd_cw   = mem_q[radr];
  assign dec_in  = (RD_LAT == 2) ? cw_q : rd_cw;
  assign res_vld = (RD_LAT == 2) ? p1_vld_q : rd_go;

  // SECDED decode: syndrome selects the bit, overall parity separates single from double errors.
  always_comb begin
    syn     = dec_in[DW+5:DW] ^ ham_chk(dec_in[DW-1:0]);
    par_bad = ^dec_in;
    dec_dat = dec_in[DW-1:0];
    dec_sbe = 1'b0;
    dec_dbe = 1'b0;
    if (syn != 6'd0) begin
      if (par_bad) begin
        dec_dat = fix_dat(dec_in[DW-1:0], syn);
        dec_sbe = 1'b1;
      end else begin
        dec_dbe = 1'b1;
      end
    end else if (par_bad) begin
      dec_sbe = 1'b1;
    end
  end

  // Read pipeline: optional raw-codeword stage, then a held result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld_q <= 1'b0;
      cw_q     <= '0;
      rdat_q   <= '0;
      rsbe_q   <= 1'b0;
      rdbe_q   <= 1'b0;
    end else begin
      p1_vld_q <= rd_go;
      if (rd_go) cw_q <= rd_cw;
      if (res_vld) begin
        rdat_q <= dec_dat;
        rsbe_q <= dec_sbe;
        rdbe_q <= dec_dbe;
      end
    end
  end

  assign rdat      = rdat_q;
  assign rsbe      = rsbe_q;
  assign rdbe      = rdbe_q;
  assign init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_mdma_40bx512_ram_slv.sv
// tb_mdma_40bx512_ram_slv: drives one RD_LAT=1 and one RD_LAT=2 instance with identical stimulus.
// Every cycle both are compared to an array-based reference model; directed vectors add fixed expectations.
// Covers zero-fill timing, read-first collisions, exact latency, optional injection and mid-read reset.
module tb_mdma_40bx512_ram_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  wadr;
  logic        wen;
  logic [39:0] wdat;
  logic        ren;
  logic [8:0]  radr;
`ifdef MDMA_RAM_ERR_INJ_EN
  logic        inj_sbe;
  logic        inj_dbe;
`endif
  logic [39:0] u1_rdat, u2_rdat;
  logic        u1_rsbe, u2_rsbe, u1_rdbe, u2_rdbe, u1_done, u2_done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mdma_40bx512_ram_slv #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wdat(wdat),
`ifdef MDMA_RAM_ERR_INJ_EN
    .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
`endif
    .ren(ren), .radr(radr), .rdat(u1_rdat), .rsbe(u1_rsbe), .rdbe(u1_rdbe), .init_done(u1_done)
  );

  mdma_40bx512_ram_slv #(.RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .wadr(wadr), .wen(wen), .wdat(wdat),
`ifdef MDMA_RAM_ERR_INJ_EN
    .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
`endif
    .ren(ren), .radr(radr), .rdat(u2_rdat), .rsbe(u2_rsbe), .rdbe(u2_rdbe), .init_done(u2_done)
  );

  // Reference model: stored data plus the kind of corruption written with it (0 clean, 1 single, 2 double).
  logic [39:0] m_dat [512];
  logic [1:0]  m_err [512];
  int          e_cnt;
  logic [41:0] exp1, exp2, pipe2;
  logic        pipe2_vld;

  // Result as {rdbe, rsbe, rdat}.
  function automatic logic [41:0] mread(input logic [8:0] a);
    case (m_err[a])
      2'd2:    return {2'b10, m_dat[a] ^ 40'h3};
      2'd1:    return {2'b01, m_dat[a]};
      default: return {2'b00, m_dat[a]};
    endcase
  endfunction

  task automatic model_reset();
    e_cnt     = 0;
    exp1      = '0;
    exp2      = '0;
    pipe2     = '0;
    pipe2_vld = 1'b0;
    for (int i = 0; i < 512; i++) begin
      m_dat[i] = '0;
      m_err[i] = 2'd0;
    end
  endtask

  // Requests count only once 513 edges have elapsed since reset release.
  task automatic model_step();
    if (e_cnt >= 513) begin
      if (pipe2_vld) exp2 = pipe2;
      pipe2_vld = ren;
      if (ren) begin
        pipe2 = mread(radr);
        exp1  = mread(radr);
      end
      if (wen) begin
        m_dat[wadr] = wdat;
        m_err[wadr] = 2'd0;
`ifdef MDMA_RAM_ERR_INJ_EN
        if (inj_dbe)      m_err[wadr] = 2'd2;
        else if (inj_sbe) m_err[wadr] = 2'd1;
`endif
      end
    end
    if (e_cnt < 100000) e_cnt++;
  endtask

  task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got dbe/sbe/dat=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    logic done_exp;
    done_exp = (e_cnt >= 513);
    chk("lat1_out", {u1_rdbe, u1_rsbe, u1_rdat}, exp1);
    chk("lat2_out", {u2_rdbe, u2_rsbe, u2_rdat}, exp2);
    chk("lat1_init_done", {41'd0, u1_done}, {41'd0, done_exp});
    chk("lat2_init_done", {41'd0, u2_done}, {41'd0, done_exp});
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic w, input logic [8:0] wa, input logic [39:0] wd,
                        input logic r, input logic [8:0] ra);
    wen  = w;
    wadr = wa;
    wdat = wd;
    ren  = r;
    radr = ra;
`ifdef MDMA_RAM_ERR_INJ_EN
    inj_sbe = 1'b0;
    inj_dbe = 1'b0;
`endif
  endtask

  typedef struct packed {
    logic        wen;
    logic [8:0]  wadr;
    logic [39:0] wdat;
    logic        ren;
    logic [8:0]  radr;
    logic        chk;
    logic [41:0] exp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h000, 1'b1, {2'b00, 40'h0}};
    tbl[1]  = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h0FF, 1'b1, {2'b00, 40'h0}};
    tbl[2]  = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h1FF, 1'b1, {2'b00, 40'h0}};
    tbl[3]  = '{1'b1, 9'h123, 40'hA5_5A5A_5A5A, 1'b0, 9'h000, 1'b0, {2'b00, 40'h0}};
    tbl[4]  = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h123, 1'b1, {2'b00, 40'hA5_5A5A_5A5A}};
    tbl[5]  = '{1'b1, 9'h007, 40'h11_2233_4455, 1'b0, 9'h000, 1'b0, {2'b00, 40'h0}};
    tbl[6]  = '{1'b1, 9'h007, 40'hFF_FFFF_FFFF, 1'b1, 9'h007, 1'b1, {2'b00, 40'h11_2233_4455}};
    tbl[7]  = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h007, 1'b1, {2'b00, 40'hFF_FFFF_FFFF}};
    tbl[8]  = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h000, 1'b1, {2'b00, 40'h0}};
    tbl[9]  = '{1'b1, 9'h1FF, 40'h80_0000_0001, 1'b0, 9'h000, 1'b0, {2'b00, 40'h0}};
    tbl[10] = '{1'b0, 9'h000, 40'h0,            1'b1, 9'h1FF, 1'b1, {2'b00, 40'h80_0000_0001}};

    set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (3) cyc();
    rst = 1'b0;

    // Zero-fill: a master write at clock 10 must be dropped.
    for (int i = 1; i <= 513; i++) begin
      if (i == 10) set_in(1'b1, 9'h000, 40'hDE_ADBE_EF00, 1'b0, 9'd0);
      else         set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
      cyc();
    end

    // Directed vectors: apply, let both pipelines settle, compare the held result.
    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].wen, tbl[i].wadr, tbl[i].wdat, tbl[i].ren, tbl[i].radr);
      cyc();
      set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
      cyc();
      cyc();
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_lat1", i), {u1_rdbe, u1_rsbe, u1_rdat}, tbl[i].exp);
        chk($sformatf("tbl%0d_lat2", i), {u2_rdbe, u2_rsbe, u2_rdat}, tbl[i].exp);
      end
    end

    // Exact latency: write, read next cycle, result appears after RD_LAT edges.
    set_in(1'b1, 9'h123, 40'hA5_5A5A_5A5A, 1'b0, 9'd0);
    cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h123);
    cyc();
    chk("lat1_at_edge_n1", {u1_rdbe, u1_rsbe, u1_rdat}, {2'b00, 40'hA5_5A5A_5A5A});
    chk("lat2_holds_at_edge_n1", {u2_rdbe, u2_rsbe, u2_rdat}, {2'b00, 40'h80_0000_0001});
    set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
    cyc();
    chk("lat2_at_edge_n2", {u2_rdbe, u2_rsbe, u2_rdat}, {2'b00, 40'hA5_5A5A_5A5A});

`ifdef MDMA_RAM_ERR_INJ_EN
    set_in(1'b1, 9'h040, 40'h12_3456_789A, 1'b0, 9'd0);
    inj_sbe = 1'b1;
    cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h040);
    cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
    cyc();
    chk("inj_sbe_lat1", {u1_rdbe, u1_rsbe, u1_rdat}, {2'b01, 40'h12_3456_789A});
    chk("inj_sbe_lat2", {u2_rdbe, u2_rsbe, u2_rdat}, {2'b01, 40'h12_3456_789A});
    set_in(1'b1, 9'h041, 40'h12_3456_789A, 1'b0, 9'd0);
    inj_dbe = 1'b1;
    inj_sbe = 1'b1;
    cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h041);
    cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
    cyc();
    chk("inj_dbe_lat1", {u1_rdbe, u1_rsbe, u1_rdat}, {2'b10, 40'h12_3456_7899});
    chk("inj_dbe_lat2", {u2_rdbe, u2_rsbe, u2_rdat}, {2'b10, 40'h12_3456_7899});
`endif

    // Random traffic on a narrow address window so collisions and rewrites are frequent.
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15)),
             {8'($urandom), 32'($urandom)},
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 9'($urandom) : 9'($urandom_range(0, 15)));
`ifdef MDMA_RAM_ERR_INJ_EN
      inj_sbe = ($urandom_range(0, 5) == 0);
      inj_dbe = ($urandom_range(0, 5) == 0);
`endif
      cyc();
    end

    // Reset in the middle of three back-to-back reads.
    set_in(1'b1, 9'h020, 40'h0F_1E2D_3C4B, 1'b0, 9'd0); cyc();
    set_in(1'b1, 9'h021, 40'h5A_6978_8796, 1'b0, 9'd0); cyc();
    set_in(1'b1, 9'h022, 40'hA5_B4C3_D2E1, 1'b0, 9'd0); cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h020); cyc();
    chk("pre_reset_lat1_nonzero", {u1_rdbe, u1_rsbe, u1_rdat}, {2'b00, 40'h0F_1E2D_3C4B});
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h021); cyc();
    #1 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h022);
    cyc();
    cyc();
    rst = 1'b0;
    set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0);
    for (int i = 1; i <= 513; i++) cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b1, 9'h020); cyc();
    set_in(1'b0, 9'd0, 40'd0, 1'b0, 9'd0); cyc(); cyc();
    chk("rezero_lat1", {u1_rdbe, u1_rsbe, u1_rdat}, {2'b00, 40'h0});
    chk("rezero_lat2", {u2_rdbe, u2_rsbe, u2_rdat}, {2'b00, 40'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
